// File: rtl/opb_regbank_pkg.sv
// Shared constants and helpers for the OPB register bank: index sizing,
// byte-lane geometry and OPB (big-endian bit numbering) to user bit mapping.
package opb_regbank_pkg;

  localparam int MAX_REGS  = 64;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int REG_IDX_W = clog2(MAX_REGS);

  // OPB bit k carries user bit 31-k.
  function automatic logic [31:0] opb_to_user(input logic [0:31] v);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[31-k] = v[k];
    return r;
  endfunction

  function automatic logic [0:31] user_to_opb(input logic [31:0] v);
    logic [0:31] r;
    for (int k = 0; k < 32; k++) r[k] = v[31-k];
    return r;
  endfunction

endpackage

// File: rtl/opb_addr_decode.sv
// Window compare and word-index extraction for the register bank.
// A pending acknowledge blocks a new hit, enforcing the two-cycle transfer.
module opb_addr_decode
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR = 32'h0000_00FF,
  parameter int          C_NUM_REGS = 4
) (
  input  logic [31:0]          addr,
  input  logic                 select,
  input  logic                 xfer_ack,
  output logic                 hit,
  output logic                 reg_valid,
  output logic [REG_IDX_W-1:0] reg_idx
);

  localparam logic [31:0] SPAN = C_HIGHADDR - C_BASEADDR;

  logic [31:0] offset;

  // A single unsigned compare on the offset covers both window bounds.
  assign offset    = addr - C_BASEADDR;
  assign hit       = select && !xfer_ack && (offset <= SPAN);
  assign reg_valid = offset[31:2] < 30'(C_NUM_REGS);
  assign reg_idx   = offset[REG_IDX_W+1:2];

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS byte-writable control registers to fabric,
// with per-register write strobes and optional self-clearing pulse registers.
module opb_register_bank_ppc2simulink
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter logic [63:0] C_PULSE_MASK = 64'h0,
  parameter string       C_FAMILY     = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:31]             OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:31]             OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:31]             Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0] user_data_out,
  output logic [C_NUM_REGS-1:0]   user_update
);

  if (C_OPB_DWIDTH != 32 || C_OPB_AWIDTH != 32 || C_NUM_REGS < 1 || C_NUM_REGS > MAX_REGS)
  begin : g_bad_cfg
    $error("opb_register_bank_ppc2simulink: unsupported parameter set");
  end

  logic [31:0]          regs [C_NUM_REGS];
  logic [31:0]          abus;
  logic                 hit;
  logic                 reg_valid;
  logic [REG_IDX_W-1:0] reg_idx;
  logic [31:0]          wdata;
  logic [31:0]          wmask;
  logic [31:0]          rd_val;
  logic [C_NUM_REGS-1:0] wr_sel;
  logic                 unused_ok;

  assign abus      = OPB_ABus;
  assign unused_ok = &{1'b0, OPB_seqAddr, (C_FAMILY != "")};

  opb_addr_decode #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR),
    .C_NUM_REGS (C_NUM_REGS)
  ) u_decode (
    .addr      (abus),
    .select    (OPB_select),
    .xfer_ack  (Sl_xferAck),
    .hit       (hit),
    .reg_valid (reg_valid),
    .reg_idx   (reg_idx)
  );

  assign wdata = opb_to_user(OPB_DBus);

  always_comb begin
    wmask  = '0;
    rd_val = '0;
    wr_sel = '0;
    for (int b = 0; b < NUM_LANES; b++)
      wmask[LANE_W*(NUM_LANES-1-b) +: LANE_W] = {LANE_W{OPB_BE[b]}};
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (reg_idx == REG_IDX_W'(i)) begin
        rd_val    = regs[i];
        wr_sel[i] = hit && !OPB_RNW && reg_valid;
      end
    end
  end

  // Pulse registers fall back to zero the cycle after they were written;
  // the ack gap guarantees no write can land in that clearing cycle.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
      user_update <= '0;
      Sl_xferAck  <= 1'b0;
      Sl_DBus     <= '0;
    end else begin
      Sl_xferAck <= hit;
      Sl_DBus    <= (hit && OPB_RNW && reg_valid) ? user_to_opb(rd_val) : '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        user_update[i] <= wr_sel[i];
        if (wr_sel[i])
          regs[i] <= (regs[i] & ~wmask) | (wdata & wmask);
        else if (C_PULSE_MASK[i])
          regs[i] <= '0;
      end
    end
  end

  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_out
    assign user_data_out[32*i +: 32] = regs[i];
  end

  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for the OPB register bank: directed scenarios plus random transfers
// checked against an array-based model of the register contents.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE  = 32'h0110_6100;
  localparam logic [31:0] HIGH  = 32'h0110_61FF;
  localparam int          NREG  = 4;
  localparam logic [63:0] PMASK = 64'h2;

  logic          clk = 1'b0;
  logic          rst;
  logic [0:31]   abus;
  logic [0:3]    be;
  logic [0:31]   dbus;
  logic          rnw;
  logic          sel;
  logic          seq;
  logic [0:31]   sl_dbus;
  logic          sl_ack, sl_err, sl_retry, sl_tout;
  logic [32*NREG-1:0] udata;
  logic [NREG-1:0]    uupd;

  int total = 0;
  int bad   = 0;
  logic [31:0] mregs [NREG];

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR   (BASE),
    .C_HIGHADDR   (HIGH),
    .C_OPB_AWIDTH (32),
    .C_OPB_DWIDTH (32),
    .C_NUM_REGS   (NREG),
    .C_PULSE_MASK (PMASK),
    .C_FAMILY     ("virtex6")
  ) dut (
    .OPB_Clk       (clk),
    .OPB_Rst       (rst),
    .OPB_ABus      (abus),
    .OPB_BE        (be),
    .OPB_DBus      (dbus),
    .OPB_RNW       (rnw),
    .OPB_select    (sel),
    .OPB_seqAddr   (seq),
    .Sl_DBus       (sl_dbus),
    .Sl_xferAck    (sl_ack),
    .Sl_errAck     (sl_err),
    .Sl_retry      (sl_retry),
    .Sl_toutSup    (sl_tout),
    .user_data_out (udata),
    .user_update   (uupd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_vec();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) v[32*i +: 32] = mregs[i];
    return v;
  endfunction

  function automatic void model_clear_pulses();
    for (int i = 0; i < NREG; i++) if (PMASK[i]) mregs[i] = 32'h0;
  endfunction

  // Applies one write to the model; returns the expected strobe vector.
  function automatic logic [NREG-1:0] model_write(input logic [31:0] addr,
                                                  input logic [3:0] bev,
                                                  input logic [31:0] data);
    logic [NREG-1:0] upd;
    int idx;
    upd = '0;
    if (addr >= BASE && addr <= HIGH) begin
      idx = int'((addr - BASE) / 4);
      if (idx < NREG) begin
        for (int j = 0; j < 4; j++) if (bev[j]) mregs[idx][8*j +: 8] = data[8*j +: 8];
        upd[idx] = 1'b1;
      end
    end
    return upd;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int idx;
    if (addr < BASE || addr > HIGH) return 32'h0;
    idx = int'((addr - BASE) / 4);
    return (idx < NREG) ? mregs[idx] : 32'h0;
  endfunction

  task automatic drive(input logic r, input logic [31:0] addr,
                       input logic [3:0] bev, input logic [31:0] data);
    sel  = 1'b1;
    rnw  = r;
    abus = addr;
    be   = bev;
    dbus = data;
  endtask

  task automatic xfer(input logic r, input logic [31:0] addr,
                      input logic [3:0] bev, input logic [31:0] data);
    logic            exp_hit;
    logic [31:0]     exp_rd;
    logic [NREG-1:0] exp_upd;
    exp_hit = (addr >= BASE) && (addr <= HIGH);
    exp_rd  = 32'h0;
    exp_upd = '0;
    if (r) exp_rd = model_read(addr);
    else   exp_upd = model_write(addr, bev, data);
    @(negedge clk);
    drive(r, addr, bev, data);
    @(posedge clk);
    #1;
    chk("ack_n1",  128'(sl_ack), 128'(exp_hit));
    chk("upd_n1",  128'(uupd), 128'(exp_upd));
    chk("dbus_n1", 128'(sl_dbus), 128'(exp_rd));
    chk("regs_n1", udata, model_vec());
    chk("const0",  128'({sl_err, sl_retry, sl_tout}), 128'(0));
    @(negedge clk);
    sel = 1'b0;
    model_clear_pulses();
    @(posedge clk);
    #1;
    chk("ack_n2",  128'(sl_ack), 128'(0));
    chk("upd_n2",  128'(uupd), 128'(0));
    chk("dbus_n2", 128'(sl_dbus), 128'(0));
    chk("regs_n2", udata, model_vec());
  endtask

  initial begin
    logic [NREG-1:0] eu;
    logic [31:0] a;
    int r;
    for (int i = 0; i < NREG; i++) mregs[i] = 32'h0;
    rst = 1'b1; sel = 1'b0; rnw = 1'b0; seq = 1'b0;
    abus = '0; be = '0; dbus = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",  128'(sl_ack), 128'(0));
    chk("rst_dbus", 128'(sl_dbus), 128'(0));
    chk("rst_regs", udata, 128'(0));
    chk("rst_upd",  128'(uupd), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // Full word write to index 2.
    xfer(1'b0, BASE + 32'h8, 4'b1111, 32'hDEADBEEF);
    // Byte-lane merge and read-back.
    xfer(1'b0, BASE, 4'b1111, 32'h11223344);
    xfer(1'b0, BASE, 4'b0100, 32'h00AA0000);
    xfer(1'b1, BASE, 4'b0000, 32'h0);
    // Zero byte enables: ack and strobe, data unchanged.
    xfer(1'b0, BASE + 32'h8, 4'b0000, 32'h12345678);
    // Pulse register.
    xfer(1'b0, BASE + 32'h4, 4'b1111, 32'h5);
    xfer(1'b1, BASE + 32'h4, 4'b1111, 32'h0);
    // Beyond the register count but inside the window, then outside.
    xfer(1'b0, BASE + 32'h28, 4'b1111, 32'hCAFEF00D);
    xfer(1'b1, BASE + 32'h28, 4'b1111, 32'h0);
    xfer(1'b1, BASE + 32'h100, 4'b1111, 32'h0);
    xfer(1'b0, BASE - 32'h4, 4'b1111, 32'h0BADBEEF);
    xfer(1'b1, HIGH, 4'b1111, 32'h0);

    // Select held high: writes are accepted every other cycle.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a  = BASE + 32'(4 * (k % NREG));
      eu = model_write(a, 4'b1111, 32'hA5A50000 + 32'(k));
      drive(1'b0, a, 4'b1111, 32'hA5A50000 + 32'(k));
      @(posedge clk);
      #1;
      chk("b2b_ack", 128'(sl_ack), 128'(1));
      chk("b2b_upd", 128'(uupd), 128'(eu));
      chk("b2b_regs", udata, model_vec());
      @(negedge clk);
      drive(1'b0, BASE + 32'hC, 4'b1111, 32'h77777777);
      model_clear_pulses();
      @(posedge clk);
      #1;
      chk("b2b_gap_ack", 128'(sl_ack), 128'(0));
      chk("b2b_gap_upd", 128'(uupd), 128'(0));
      chk("b2b_gap_regs", udata, model_vec());
    end
    @(negedge clk);
    sel = 1'b0;
    @(posedge clk);

    // Randomized transfers.
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = BASE + 32'h100 + ($urandom & 32'hFC);
      else if (r == 1) a = BASE - 32'(4 * $urandom_range(1, 8));
      else if (r < 4)  a = BASE + 32'(4 * $urandom_range(NREG, 63));
      else             a = BASE + 32'(4 * $urandom_range(0, NREG - 1));
      a = a + 32'($urandom_range(0, 3));
      xfer(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
    end

    // Reset colliding with a hit.
    xfer(1'b0, BASE + 32'hC, 4'b1111, 32'hFFFFFFFF);
    @(negedge clk);
    drive(1'b0, BASE + 32'hC, 4'b1111, 32'h0000FFFF);
    rst = 1'b1;
    for (int i = 0; i < NREG; i++) mregs[i] = 32'h0;
    @(posedge clk);
    #1;
    chk("rsthit_ack", 128'(sl_ack), 128'(0));
    chk("rsthit_upd", 128'(uupd), 128'(0));
    chk("rsthit_regs", udata, model_vec());
    chk("rsthit_const", 128'({sl_err, sl_retry, sl_tout}), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, BASE, 4'b1111, 32'h12345678);
    eu = model_write(BASE, 4'b1111, 32'h12345678);
    @(posedge clk);
    #1;
    chk("post_rst_ack", 128'(sl_ack), 128'(1));
    chk("post_rst_upd", 128'(uupd), 128'(eu));
    chk("post_rst_regs", udata, model_vec());
    @(negedge clk);
    sel = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_gap", 128'(sl_ack), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
